alu_seq_exec: RTL and testbench

- Execution-side consumer of the 4-bit ALUControl code generated by the CPU's ALU decoder.
- Registered, start/done-handshaked ALU:
  - Arithmetic, logic and compare ops complete in one cycle.
  - Shifts iterate one bit position per clock, using a single 1-bit shifter instead of a barrel shifter to save area on the bot's FPGA.
- Sits in the execute stage. The core stalls on `busy` and latches the result on `done`.

---
 rtl/alu_ctrl_pkg.sv | 40 ++++
 rtl/alu_comb_core.sv | 36 +++
 rtl/alu_seq_exec.sv | 135 +++++++++++++
 tb/tb_alu_seq_exec.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALUControl encoding and execute-stage state types, used by the ALU
// decoder and by alu_seq_exec.
`timescale 1ns/1ps
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_ADDS = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_e;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

  function automatic shift_kind_e shift_kind(input logic [3:0] ctrl);
    if (ctrl == ALU_SLL)      return SH_SLL;
    else if (ctrl == ALU_SRA) return SH_SRA;
    else                      return SH_SRL;
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle add/sub/logic/compare unit with illegal-code detection.
// Shift codes are recognised as legal but produce no result here.
`timescale 1ns/1ps
module alu_comb_core
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             illegal_o
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (ctrl_i)
      ALU_ADD, ALU_ADDS: result_o = a_i + b_i;
      ALU_SUB:           result_o = a_i - b_i;
      ALU_AND:           result_o = a_i & b_i;
      ALU_OR:            result_o = a_i | b_i;
      ALU_XOR:           result_o = a_i ^ b_i;
      ALU_SLT:           result_o = WIDTH'($signed(a_i) < $signed(b_i));
      ALU_SLTU:          result_o = WIDTH'(a_i < b_i);
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        // sequenced by the caller, one bit per clock
      end
      default:           illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Registered start/done ALU for the execute stage. Non-shift ops finish in one
// cycle; shifts step a 1-bit shifter once per clock for b[SHAMT_W-1:0] clocks.
`timescale 1ns/1ps
module alu_seq_exec
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  alu_state_e         state_q, state_d;
  shift_kind_e        kind_q, kind_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;

  logic [WIDTH-1:0]   core_result;
  logic               core_illegal;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .ctrl_i    (alu_ctrl),
    .a_i       (a),
    .b_i       (b),
    .result_o  (core_result),
    .illegal_o (core_illegal)
  );

  assign shamt  = b[SHAMT_W-1:0];
  assign accept = start && (state_q != SHIFT);

  always_comb begin
    shifted = {1'b0, sreg_q[WIDTH-1:1]};
    case (kind_q)
      SH_SLL:  shifted = {sreg_q[WIDTH-2:0], 1'b0};
      SH_SRA:  shifted = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
      default: shifted = {1'b0, sreg_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_shift(alu_ctrl)) begin
            illegal_d = 1'b0;
            if (shamt == '0) begin
              result_d = a;
              zero_d   = (a == '0);
              state_d  = DONE;
            end else begin
              sreg_d  = a;
              cnt_d   = shamt;
              kind_d  = shift_kind(alu_ctrl);
              state_d = SHIFT;
            end
          end else begin
            result_d  = core_result;
            zero_d    = (core_result == '0);
            illegal_d = core_illegal;
            state_d   = DONE;
          end
        end else begin
          illegal_d = 1'b0;
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        sreg_d = shifted;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = shifted;
          zero_d   = (shifted == '0);
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      kind_q    <= SH_SLL;
      sreg_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign ready   = (state_q != SHIFT);
  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed cases followed by random ops
// compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected result, illegal flag and done latency (cycles after accept).
  function automatic void model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill, output int lat);
    int n;
    n   = int'(y[4:0]);
    ill = 1'b0;
    lat = 1;
    case (c)
      4'b0000, 4'b1001: r = x + y;
      4'b0001: r = x - y;
      4'b0010: r = x & y;
      4'b0011: r = x | y;
      4'b0110: r = x ^ y;
      4'b0101: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1101: r = (x < y) ? 32'd1 : 32'd0;
      4'b0100: begin r = x << n; lat = n + 1; end
      4'b1000: begin r = x >> n; lat = n + 1; end
      4'b0111: begin r = $unsigned($signed(x) >>> n); lat = n + 1; end
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
  endfunction

  logic [31:0] last_result;

  // Issue one op from a post-edge point; returns #1 after the edge that raised done.
  task automatic do_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                       input int poke_at);
    logic [31:0] er;
    logic        ei;
    int          lat, cyc, busy_cnt;
    model(c, x, y, er, ei, lat);
    check("ready_at_issue", 32'(ready), 32'd1);
    start = 1'b1; alu_ctrl = c; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (cyc == poke_at) begin
        start = 1'b1; alu_ctrl = 4'b0000; a = $urandom; b = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("done", 32'(done), 32'd1);
    check("latency", 32'(cyc), 32'(lat));
    check("busy_cycles", 32'(busy_cnt), 32'(lat - 1));
    check("done_busy", 32'(busy), 32'd0);
    check("result", result, er);
    check("zero", 32'(zero), 32'(er == 32'd0));
    check("illegal", 32'(illegal), 32'(ei));
    last_result = er;
  endtask

  initial begin
    int done_cnt;
    logic [3:0] legal [11];
    logic [3:0] c;
    logic [31:0] x, y;
    legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
              4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1101};

    reset = 1'b1; start = 1'b0; alu_ctrl = 4'b0000; a = '0; b = '0;
    #2;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    do_op(4'b0000, 32'd5, 32'd7, 0);
    check("add_5_7", result, 32'd12);
    do_op(4'b0001, 32'd3, 32'd3, 0);
    check("sub_zero", 32'(zero), 32'd1);
    do_op(4'b0101, 32'hFFFF_FFFF, 32'd1, 0);
    check("slt_neg", result, 32'd1);
    do_op(4'b1101, 32'hFFFF_FFFF, 32'd1, 0);
    check("sltu_big", result, 32'd0);
    do_op(4'b0100, 32'd1, 32'd31, 10);
    check("sll_31", result, 32'h8000_0000);
    do_op(4'b0111, 32'h8000_0000, 32'd4, 0);
    check("sra_4", result, 32'hF800_0000);
    do_op(4'b1000, 32'h8000_0000, 32'd4, 0);
    check("srl_4", result, 32'h0800_0000);
    do_op(4'b1000, 32'h8000_0000, 32'd0, 0);
    check("srl_0", result, 32'h8000_0000);
    do_op(4'b1111, 32'h1234_5678, 32'h9, 0);
    do_op(4'b0000, 32'd1, 32'd2, 0);
    check("b2b_after_illegal", 32'(illegal), 32'd0);
    do_op(4'b1010, 32'd7, 32'd7, 0);
    @(posedge clk); #1;
    check("illegal_clears_idle", 32'(illegal), 32'd0);
    check("idle_after_done", 32'(done), 32'd0);

    // Abort a 20-position shift with an asynchronous reset mid-flight.
    do_op(4'b0000, 32'h10, 32'h20, 0);
    start = 1'b1; alu_ctrl = 4'b0100; a = 32'h3; b = 32'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    check("pre_abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_zero", 32'(zero), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    done_cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    check("no_done_after_abort", 32'(done_cnt), 32'd0);
    check("result_after_abort", result, 32'd0);
    do_op(4'b0000, 32'd5, 32'd7, 0);
    check("add_after_abort", result, 32'd12);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 15));
      else c = legal[$urandom_range(0, 10)];
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) x = 32'h8000_0000 | x[7:0];
      if ($urandom_range(0, 3) == 0) y = x;
      do_op(c, x, y, $urandom_range(0, 3) == 0 ? 2 : 0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        check("gap_done", 32'(done), 32'd0);
        check("gap_illegal", 32'(illegal), 32'd0);
        check("gap_hold", result, last_result);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
